// File: rtl/uart_pkg.sv
// ------------------------------------------------------------------------
// uart_pkg : shared UART types, oversampling ratio and baud divider helper
// Rev 1.0   (ST_PARITY exists only with UART_RX_PARITY_EN)
// ------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

   localparam int OSR = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
      ST_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
      ,
      ST_PARITY = 3'd5
`endif
   } uart_rx_state_t;

   // Oversample tick divider, rounded to nearest and never below 1.
   function automatic int uart_div(input int clk_hz, input int baud);
      int d;
      d = (clk_hz + (OSR / 2) * baud) / (OSR * baud);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
// ------------------------------------------------------------------------
// uart_rx_fifo_if : valid/ready byte stream out of the UART receive FIFO
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

interface uart_rx_fifo_if;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;

   modport master (output m_data, output m_valid, input m_ready);
   modport slave  (input m_data, input m_valid, output m_ready);
endinterface

`default_nettype wire

// File: rtl/uart_rx_fifo_sync_fifo.sv
// ------------------------------------------------------------------------
// sync_fifo : first-word-fall-through FIFO; a push while full is accepted
//             only when a pop retires an entry in the same cycle. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         push_data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         pop_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int c_AW = $clog2(DEPTH);
   localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [c_AW-1:0]  wr_ptr_q;
   logic [c_AW-1:0]  rd_ptr_q;
   logic [c_AW:0]    level_q;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign empty_o    = (level_q == '0);
   assign full_o     = (level_q == c_FULL);
   assign level_o    = level_q;
   assign w_pop_ok   = pop_i & ~empty_o;
   assign w_push_ok  = push_i & (~full_o | w_pop_ok);
   // Head is forced to zero while empty so stale storage never leaks out.
   assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (w_push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ------------------------------------------------------------------------
// uart_rx_fifo : 16x oversampled UART receiver (8N1, or 8E1 with
//                UART_RX_PARITY_EN) feeding an FWFT receive FIFO. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rxd,
   uart_rx_fifo_if.master                m_if,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          frame_err,
`ifdef UART_RX_PARITY_EN
   output logic                          parity_err,
`endif
   output logic                          overrun
);

   localparam int              c_DIV       = uart_div(CLK_HZ, BAUD);
   localparam int              c_TW        = (c_DIV > 1) ? $clog2(c_DIV) : 1;
   localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(c_DIV - 1);
   localparam logic [3:0]      c_MID       = 4'(OSR / 2 - 1);
   localparam logic [3:0]      c_LAST      = 4'(OSR - 1);

   logic [1:0]      sync_q;
   logic            w_rxs;
   uart_rx_state_t  state_q, state_d;
   logic [c_TW-1:0] tick_q, tick_d;
   logic [3:0]      samp_q, samp_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            frame_err_q, frame_err_d;
   logic            overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
   logic            par_bad_q, par_bad_d;
   logic            parity_err_q, parity_err_d;
`endif
   logic            w_tick;
   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic [7:0]      w_head;

   assign w_rxs  = sync_q[1];
   assign w_tick = (state_q != ST_IDLE) && (tick_q == c_TICK_LAST);
   assign w_pop  = m_if.m_valid & m_if.m_ready;

   always_comb begin
      state_d     = state_q;
      samp_d      = samp_q;
      bit_d       = bit_q;
      shreg_d     = shreg_q;
      w_push      = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif
      // The divider only runs inside a frame so bit timing anchors on the start edge.
      if ((state_q == ST_IDLE) || w_tick) begin
         tick_d = '0;
      end else begin
         tick_d = tick_q + 1'b1;
      end
      if (w_tick) begin
         samp_d = samp_q + 4'd1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (!w_rxs) begin
               state_d = ST_START;
               samp_d  = '0;
            end
         end
         ST_START: begin
            if (w_tick && (samp_q == c_MID)) begin
               samp_d = '0;
               if (w_rxs) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DATA;
                  bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                  par_bad_d = 1'b0;
`endif
               end
            end
         end
         ST_DATA: begin
            if (w_tick && (samp_q == c_LAST)) begin
               shreg_d = {w_rxs, shreg_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (w_tick && (samp_q == c_LAST)) begin
               par_bad_d    = ^{shreg_q, w_rxs};
               parity_err_d = ^{shreg_q, w_rxs};
               state_d      = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (w_tick && (samp_q == c_LAST)) begin
               if (w_rxs) begin
`ifdef UART_RX_PARITY_EN
                  w_push = ~par_bad_q;
`else
                  w_push = 1'b1;
`endif
                  state_d = ST_IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            if (w_rxs) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      overrun_d = w_push & w_full & ~w_pop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q      <= 2'b11;
         state_q     <= ST_IDLE;
         tick_q      <= '0;
         samp_q      <= '0;
         bit_q       <= '0;
         shreg_q     <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         sync_q      <= {sync_q[0], rxd};
         state_q     <= state_d;
         tick_q      <= tick_d;
         samp_q      <= samp_d;
         bit_q       <= bit_d;
         shreg_q     <= shreg_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (w_push),
      .push_data_i (shreg_q),
      .pop_i       (m_if.m_ready),
      .pop_data_o  (w_head),
      .full_o      (w_full),
      .empty_o     (w_empty),
      .level_o     (fifo_level)
   );

   assign m_if.m_data  = w_head;
   assign m_if.m_valid = ~w_empty;
   assign frame_err    = frame_err_q;
   assign overrun      = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err   = parity_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ------------------------------------------------------------------------
// tb_uart_rx_fifo : directed bench for uart_rx_fifo at 16 clk per bit,
//                   FIFO_DEPTH 4 (parity cases with UART_RX_PARITY_EN). Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_fifo;

`ifdef UART_RX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int POP_J = 16 * (NB - 1) + 10;
   localparam int LAT_T = (16 * (NB - 1) + 11) * 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic [2:0] lvl;
   logic       fe;
   logic       ov;
`ifdef UART_RX_PARITY_EN
   logic       pe;
`endif

   uart_rx_fifo_if u_if ();

   uart_rx_fifo #(
      .CLK_HZ     (1600),
      .BAUD       (100),
      .FIFO_DEPTH (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .m_if       (u_if),
      .fifo_level (lvl),
      .frame_err  (fe),
`ifdef UART_RX_PARITY_EN
      .parity_err (pe),
`endif
      .overrun    (ov)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   int   fe_cnt = 0;
   int   ov_cnt = 0;
   int   pe_cnt = 0;
   time  rise_t = 0;
   time  start_t = 0;
   logic prev_v = 1'b0;

   always @(negedge clk) begin
      if (fe) fe_cnt++;
      if (ov) ov_cnt++;
`ifdef UART_RX_PARITY_EN
      if (pe) pe_cnt++;
`endif
      if (u_if.m_valid && !prev_v) rise_t = $time;
      prev_v = u_if.m_valid;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame, one bit per 16 clocks; pop_at >= 0 pulses m_ready at that clock.
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok,
                             input int pop_at);
      logic [NB-1:0] bits;
`ifdef UART_RX_PARITY_EN
      bits = {stop, (^d) ^ ~par_ok, d, 1'b0};
`else
      bits = {stop, d, 1'b0};
      if (!par_ok) bits[0] = 1'b0;
`endif
      start_t = $time;
      for (int j = 0; j < NB * 16; j++) begin
         rxd = bits[j / 16];
         if (pop_at >= 0) u_if.m_ready = (j == pop_at);
         @(negedge clk);
      end
      if (pop_at >= 0) u_if.m_ready = 1'b0;
   endtask

   task automatic pop_expect(input string name, input logic [7:0] exp);
      check({name, " valid"}, {31'd0, u_if.m_valid}, 32'd1);
      check({name, " data"}, {24'd0, u_if.m_data}, {24'd0, exp});
      u_if.m_ready = 1'b1;
      @(negedge clk);
      u_if.m_ready = 1'b0;
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_valid;
      logic [7:0] exp_data;
      int         exp_fe;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int fe0, ov0, pe0;
      vecs[0] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 0};
      vecs[1] = '{8'h55, 1'b0, 1'b0, 8'h00, 1};
      vecs[2] = '{8'h81, 1'b1, 1'b1, 8'h81, 0};
      vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
      vecs[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
      vecs[5] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 0};

      u_if.m_ready = 1'b0;
      rst = 1'b1;
      rxd = 1'b1;
      repeat (3) @(negedge clk);
      check("reset m_valid", {31'd0, u_if.m_valid}, 32'd0);
      check("reset m_data", {24'd0, u_if.m_data}, 32'd0);
      check("reset level", {29'd0, lvl}, 32'd0);
      check("reset frame_err", {31'd0, fe}, 32'd0);
      check("reset overrun", {31'd0, ov}, 32'd0);
      rst = 1'b0;
      idle(5);

      // Single frame: latency from start drive, head byte, level, then pop.
      send_frame(8'hA5, 1'b1, 1'b1, -1);
      check("A5 latency", 32'(rise_t - start_t), LAT_T);
      check("A5 data", {24'd0, u_if.m_data}, 32'hA5);
      check("A5 level", {29'd0, lvl}, 32'd1);
      u_if.m_ready = 1'b1;
      @(negedge clk);
      u_if.m_ready = 1'b0;
      check("A5 popped valid", {31'd0, u_if.m_valid}, 32'd0);

      // Glitch shorter than half a bit must be ignored.
      fe0 = fe_cnt;
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      idle(40);
      check("glitch level", {29'd0, lvl}, 32'd0);
      check("glitch frame_err", fe_cnt - fe0, 0);

      for (int i = 0; i < 6; i++) begin
         fe0 = fe_cnt;
         send_frame(vecs[i].data, vecs[i].stop, 1'b1, -1);
         if (!vecs[i].stop) begin
            rxd = 1'b0;
            repeat (40) @(negedge clk);
         end
         idle(20);
         check($sformatf("vec%0d valid", i), {31'd0, u_if.m_valid}, {31'd0, vecs[i].exp_valid});
         check($sformatf("vec%0d level", i), {29'd0, lvl}, {31'd0, vecs[i].exp_valid});
         check($sformatf("vec%0d frame_err", i), fe_cnt - fe0, vecs[i].exp_fe);
         if (vecs[i].exp_valid) begin
            pop_expect($sformatf("vec%0d", i), vecs[i].exp_data);
         end
      end

      // Overrun: fifth byte dropped, first four retained in order.
      ov0 = ov_cnt;
      for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b1, -1);
      idle(20);
      check("ovr pulses", ov_cnt - ov0, 1);
      check("ovr level", {29'd0, lvl}, 32'd4);
      for (int b = 1; b <= 4; b++) pop_expect($sformatf("ovr drain%0d", b), 8'(b));
      check("ovr empty", {31'd0, u_if.m_valid}, 32'd0);

      // Full FIFO with a pop on the push cycle accepts the new byte.
      ov0 = ov_cnt;
      for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1, 1'b1, -1);
      send_frame(8'h05, 1'b1, 1'b1, POP_J);
      idle(20);
      check("fullpop overrun", ov_cnt - ov0, 0);
      check("fullpop level", {29'd0, lvl}, 32'd4);
      for (int b = 2; b <= 5; b++) pop_expect($sformatf("fullpop drain%0d", b), 8'(b));
      check("fullpop empty", {31'd0, u_if.m_valid}, 32'd0);

      // Reset in the middle of data bit 3 with a byte already queued.
      send_frame(8'h42, 1'b1, 1'b1, -1);
      rxd = 1'b0;
      repeat (16 * 4 + 8) @(negedge clk);
      rst = 1'b1;
      rxd = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst m_valid", {31'd0, u_if.m_valid}, 32'd0);
      check("midrst m_data", {24'd0, u_if.m_data}, 32'd0);
      check("midrst level", {29'd0, lvl}, 32'd0);
      rst = 1'b0;
      idle(20);
      check("midrst no frame", {29'd0, lvl}, 32'd0);

`ifdef UART_RX_PARITY_EN
      pe0 = pe_cnt;
      fe0 = fe_cnt;
      send_frame(8'h07, 1'b1, 1'b0, -1);
      idle(20);
      check("par bad pulses", pe_cnt - pe0, 1);
      check("par bad level", {29'd0, lvl}, 32'd0);
      check("par bad frame_err", fe_cnt - fe0, 0);
      send_frame(8'h07, 1'b1, 1'b1, -1);
      idle(20);
      check("par good pulses", pe_cnt - pe0, 1);
      check("par good level", {29'd0, lvl}, 32'd1);
      pop_expect("par good", 8'h07);
`else
      pe0 = pe_cnt;
      send_frame(8'h99, 1'b1, 1'b1, -1);
      idle(20);
      check("post-rst level", {29'd0, lvl}, 32'd1);
      check("post-rst parity", pe_cnt - pe0, 0);
      pop_expect("post-rst", 8'h99);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
